decoder_upsample_fuse: RTL

Streaming decoder stage that upsamples a low-resolution feature map by an integer power-of-two factor (nearest neighbour) and optionally fuses it element-wise with a same-resolution skip-connection stream. It adds a saturating signed add and an optional ReLU. It sits between the bottleneck/previous decoder stage and the next decoder stage. It replaces whole-array ports with valid/ready element streams in channels-last raster order, index (y*W + x)*CH + c. Unlike the fixed three-stage decoder, it is generic in width, height, channel count and scale, and is instantiated once per decoder stage.

---
 rtl/decoder_pkg.sv | 15 +
 rtl/decoder_upsample_fuse_if.sv | 21 ++
 rtl/decoder_upsample_fuse_sat_add_relu.sv | 29 ++
 rtl/decoder_upsample_fuse.sv | 136 +++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared decoder-stage types and saturation limits
package decoder_pkg;

  // Streams are channels-last raster order: element index = (y*W + x)*CH + c.
  typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/decoder_upsample_fuse_if.sv
// rtl/decoder_upsample_fuse_if.sv - control and element-stream bundle of a decoder stage
interface decoder_upsample_fuse_if #(parameter int DATA_W = 16);
  logic              start, skip_en, relu_en;
  logic              busy, done, sat_flag;
  logic [DATA_W-1:0] in_data;
  logic              in_valid, in_ready;
  logic [DATA_W-1:0] skip_data;
  logic              skip_valid, skip_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_ready;

  modport master (
    output start, skip_en, relu_en, in_data, in_valid, skip_data, skip_valid, out_ready,
    input  busy, done, sat_flag, in_ready, skip_ready, out_data, out_valid
  );

  modport slave (
    input  start, skip_en, relu_en, in_data, in_valid, skip_data, skip_valid, out_ready,
    output busy, done, sat_flag, in_ready, skip_ready, out_data, out_valid
  );
endinterface

// File: rtl/decoder_upsample_fuse_sat_add_relu.sv
// rtl/decoder_upsample_fuse_sat_add_relu.sv - saturating signed add with optional skip and ReLU
module sat_add_relu
  import decoder_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         skip_en,
  input  logic         relu_en,
  output logic [W-1:0] y,
  output logic         sat
);
  localparam logic [W-1:0] MAX_V = W'(sat_max(W));
  localparam logic [W-1:0] MIN_V = W'(sat_min(W));

  logic [W:0]   sum;
  logic [W-1:0] clamped;

  always_comb begin
    sum = {a[W-1], a} + (skip_en ? {b[W-1], b} : '0);
    // Overflow shows as disagreement between the guard bit and the sign bit.
    sat = (sum[W] != sum[W-1]);
    if (!sat)        clamped = sum[W-1:0];
    else if (sum[W]) clamped = MIN_V;
    else             clamped = MAX_V;
    y = (relu_en && clamped[W-1]) ? '0 : clamped;
  end
endmodule

// File: rtl/decoder_upsample_fuse.sv
// rtl/decoder_upsample_fuse.sv - nearest-neighbour upsample with optional skip fuse and ReLU
module decoder_upsample_fuse
  import decoder_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int IN_W   = 2,
  parameter int IN_H   = 2,
  parameter int CH     = 128,
  parameter int SCALE  = 2
) (
  input logic clk,
  input logic rst,
  decoder_upsample_fuse_if.slave bus
);
  localparam int LB_D = IN_W * CH;
  localparam int AW   = (LB_D > 1) ? $clog2(LB_D) : 1;
  localparam int XW   = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1;
  localparam int RW   = (IN_H > 1) ? $clog2(IN_H) : 1;
  localparam int SW   = $clog2(SCALE);

  state_t            state;
  logic              skip_q, relu_q, draining;
  logic [AW-1:0]     wr, rd_addr;
  logic [RW-1:0]     row;
  logic [SW-1:0]     r, k;
  logic [XW-1:0]     x;
  logic [CW-1:0]     c;
  logic [DATA_W-1:0] lb [LB_D];
  logic [DATA_W-1:0] res;
  logic              sat, load, in_fire;

  assign rd_addr       = AW'(int'(x) * CH + int'(c));
  assign in_fire       = (state == LOAD) && bus.in_valid;
  assign bus.in_ready  = (state == LOAD);
  assign load          = (state == EMIT) && !draining &&
                         (!bus.out_valid || bus.out_ready) && (bus.skip_valid || !skip_q);
  assign bus.skip_ready = load && skip_q;

  sat_add_relu #(.W(DATA_W)) u_sat (
    .a       (lb[rd_addr]),
    .b       (bus.skip_data),
    .skip_en (skip_q),
    .relu_en (relu_q),
    .y       (res),
    .sat     (sat)
  );

  always_ff @(posedge clk) begin
    if (in_fire) lb[wr] <= bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.sat_flag  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      skip_q        <= 1'b0;
      relu_q        <= 1'b0;
      draining      <= 1'b0;
      wr            <= '0;
      row           <= '0;
      r             <= '0;
      k             <= '0;
      x             <= '0;
      c             <= '0;
    end else begin
      bus.done <= 1'b0;
      if (bus.out_valid && bus.out_ready) bus.out_valid <= 1'b0;
      if (load) begin
        bus.out_data  <= res;
        bus.out_valid <= 1'b1;
        if (sat) bus.sat_flag <= 1'b1;
      end
      case (state)
        IDLE: if (bus.start) begin
          skip_q       <= bus.skip_en;
          relu_q       <= bus.relu_en;
          bus.sat_flag <= 1'b0;
          bus.busy     <= 1'b1;
          draining     <= 1'b0;
          wr  <= '0; row <= '0; r <= '0; k <= '0; x <= '0; c <= '0;
          state        <= LOAD;
        end
        LOAD: if (bus.in_valid) begin
          if (wr == AW'(LB_D - 1)) begin
            wr    <= '0;
            state <= EMIT;
          end else begin
            wr <= wr + 1'b1;
          end
        end
        EMIT: begin
          if (load) begin
            if (c != CW'(CH - 1)) c <= c + 1'b1;
            else begin
              c <= '0;
              if (k != SW'(SCALE - 1)) k <= k + 1'b1;
              else begin
                k <= '0;
                if (x != XW'(IN_W - 1)) x <= x + 1'b1;
                else begin
                  x <= '0;
                  if (r != SW'(SCALE - 1)) r <= r + 1'b1;
                  else begin
                    r <= '0;
                    if (row == RW'(IN_H - 1)) draining <= 1'b1;
                    else begin
                      row   <= row + 1'b1;
                      state <= LOAD;
                    end
                  end
                end
              end
            end
          end
          // Hold off DONE until the final element has left the output register.
          if (draining && bus.out_valid && bus.out_ready) begin
            draining <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
